// File: rtl/edge_event_bank_pkg.sv
// edge_event_bank_pkg: default parameters and width helpers shared by the edge/event bank.
package edge_event_bank_pkg;

    localparam int unsigned DEF_NUM_CH        = 8;
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_FILTER_CYCLES = 4;
    localparam int unsigned DEF_COUNT_W       = 8;

    // Filter counter must hold 0..FILTER_CYCLES.
    function automatic int unsigned filt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/edge_event_bank_if.sv
// edge_event_bank_if: raw inputs, controls and event outputs of the edge/event bank.
interface edge_event_bank_if
    import edge_event_bank_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned COUNT_W = DEF_COUNT_W
);

    logic [NUM_CH-1:0]         din;
    logic [NUM_CH-1:0]         rise_en;
    logic [NUM_CH-1:0]         fall_en;
    logic [NUM_CH-1:0]         clr;
    logic [NUM_CH-1:0]         level;
    logic [NUM_CH-1:0]         rise_pulse;
    logic [NUM_CH-1:0]         fall_pulse;
    logic [NUM_CH-1:0]         pending;
    logic [NUM_CH*COUNT_W-1:0] event_cnt;
    logic                      irq;

    modport master (
        output din, rise_en, fall_en, clr,
        input  level, rise_pulse, fall_pulse, pending, event_cnt, irq
    );

    modport slave (
        input  din, rise_en, fall_en, clr,
        output level, rise_pulse, fall_pulse, pending, event_cnt, irq
    );

endinterface

// File: rtl/edge_event_ch.sv
// edge_event_ch: one channel -- synchroniser, glitch filter, edge pulses, sticky pending and saturating counter.
module edge_event_ch
    import edge_event_bank_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int unsigned COUNT_W       = DEF_COUNT_W,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_i,
    input  logic               rise_en_i,
    input  logic               fall_en_i,
    input  logic               clr_i,
    output logic               level_o,
    output logic               rise_pulse_o,
    output logic               fall_pulse_o,
    output logic               pending_o,
    output logic [COUNT_W-1:0] event_cnt_o
);

    localparam int unsigned        FW   = filt_w(FILTER_CYCLES);
    localparam logic [FW-1:0]      LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [COUNT_W-1:0] MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FW-1:0]          cnt_q, cnt_d;
    logic [COUNT_W-1:0]     ecnt_q, ecnt_d;
    logic level_q, level_d, rise_q, rise_d, fall_q, fall_d, pend_q, pend_d;
    logic s, ev, flip;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din_i};
        s       = sync_q[SYNC_STAGES-1];
        flip    = (s != level_q) && (cnt_q == LAST);
        cnt_d   = (s == level_q || flip) ? '0 : cnt_q + 1'b1;
        level_d = flip ? s : level_q;
        rise_d  = flip & s;
        fall_d  = flip & ~s;
        ev      = (rise_q & rise_en_i) | (fall_q & fall_en_i);
        // A new event outranks a clear arriving in the same cycle.
        pend_d  = ev | (pend_q & ~clr_i);
        ecnt_d  = clr_i ? COUNT_W'(ev) : (ev && ecnt_q != MAX) ? ecnt_q + 1'b1 : ecnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q   <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            pend_q  <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign level_o      = level_q;
    assign rise_pulse_o = rise_q;
    assign fall_pulse_o = fall_q;
    assign pending_o    = pend_q;
    assign event_cnt_o  = ecnt_q;

endmodule

// File: rtl/edge_event_bank.sv
// edge_event_bank: NUM_CH independent filtered edge/event channels with an OR-reduced interrupt.
module edge_event_bank
    import edge_event_bank_pkg::*;
#(
    parameter int unsigned NUM_CH        = DEF_NUM_CH,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int unsigned COUNT_W       = DEF_COUNT_W,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input logic              clk,
    input logic              rst,
    edge_event_bank_if.slave bus
);

    logic [NUM_CH-1:0]         level, rise_pulse, fall_pulse, pending;
    logic [NUM_CH*COUNT_W-1:0] event_cnt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_event_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .COUNT_W      (COUNT_W),
            .INIT_LEVEL   (INIT_LEVEL)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .din_i       (bus.din[i]),
            .rise_en_i   (bus.rise_en[i]),
            .fall_en_i   (bus.fall_en[i]),
            .clr_i       (bus.clr[i]),
            .level_o     (level[i]),
            .rise_pulse_o(rise_pulse[i]),
            .fall_pulse_o(fall_pulse[i]),
            .pending_o   (pending[i]),
            .event_cnt_o (event_cnt[i*COUNT_W +: COUNT_W])
        );
    end

    assign bus.level      = level;
    assign bus.rise_pulse = rise_pulse;
    assign bus.fall_pulse = fall_pulse;
    assign bus.pending    = pending;
    assign bus.event_cnt  = event_cnt;
    assign bus.irq        = |pending;

endmodule

// File: tb/tb_edge_event_bank.sv
// tb_edge_event_bank: directed checks of filtering, edge modes, clear priority, saturation and reset.
module tb_edge_event_bank;

    localparam int NCH = 8;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   nr, nf;

    always #5 clk = ~clk;

    edge_event_bank_if #(.NUM_CH(NCH), .COUNT_W(CW)) bus ();

    edge_event_bank #(
        .NUM_CH       (NCH),
        .SYNC_STAGES  (2),
        .FILTER_CYCLES(4),
        .COUNT_W      (CW),
        .INIT_LEVEL   (1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int n, input int ch);
        repeat (n) begin
            tick(1);
            nr += int'(bus.rise_pulse[ch]);
            nf += int'(bus.fall_pulse[ch]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return bus.event_cnt[ch*CW +: CW];
    endfunction

    initial begin
        rst         = 1'b1;
        bus.din     = '0;
        bus.rise_en = '0;
        bus.fall_en = '0;
        bus.clr     = '0;
        tick(2);
        rst = 1'b0;
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_pulses", 32'(bus.rise_pulse | bus.fall_pulse), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_cnt", 32'(bus.event_cnt), 0);
        chk("rst_irq", 32'(bus.irq), 0);

        // Clean rise on channel 0: visible after edge 5, event after edge 6.
        bus.rise_en[0] = 1'b1;
        bus.din[0]     = 1'b1;
        tick(5);
        chk("rise_level_e4", 32'(bus.level[0]), 0);
        tick(1);
        chk("rise_level_e5", 32'(bus.level[0]), 1);
        chk("rise_pulse_e5", 32'(bus.rise_pulse[0]), 1);
        chk("rise_pend_e5", 32'(bus.pending[0]), 0);
        tick(1);
        chk("rise_pulse_e6", 32'(bus.rise_pulse[0]), 0);
        chk("rise_pend_e6", 32'(bus.pending[0]), 1);
        chk("rise_cnt_e6", 32'(cnt_of(0)), 1);
        chk("rise_irq_e6", 32'(bus.irq), 1);

        // Glitch of 3 cycles on channel 3 never reaches level.
        bus.rise_en[3] = 1'b1;
        bus.fall_en[3] = 1'b1;
        nr = 0; nf = 0;
        bus.din[3] = 1'b1;
        run(3, 3);
        bus.din[3] = 1'b0;
        run(10, 3);
        chk("glitch_rise", 32'(nr), 0);
        chk("glitch_fall", 32'(nf), 0);
        chk("glitch_level", 32'(bus.level[3]), 0);
        chk("glitch_pend", 32'(bus.pending[3]), 0);

        // A 6-cycle pulse passes as one rise and one fall, both counted.
        nr = 0; nf = 0;
        bus.din[3] = 1'b1;
        run(6, 3);
        bus.din[3] = 1'b0;
        run(12, 3);
        chk("pulse6_rise", 32'(nr), 1);
        chk("pulse6_fall", 32'(nf), 1);
        chk("pulse6_level", 32'(bus.level[3]), 0);
        chk("pulse6_cnt", 32'(cnt_of(3)), 2);

        // Falling-only on channel 1: two pulses, one event.
        bus.fall_en[1] = 1'b1;
        nr = 0; nf = 0;
        bus.din[1] = 1'b1;
        run(10, 1);
        bus.din[1] = 1'b0;
        run(10, 1);
        chk("fall_only_rise", 32'(nr), 1);
        chk("fall_only_fall", 32'(nf), 1);
        chk("fall_only_cnt", 32'(cnt_of(1)), 1);
        chk("fall_only_pend", 32'(bus.pending[1]), 1);

        // Clear everything pending so irq can be observed per channel.
        bus.clr = 8'b0000_1011;
        tick(1);
        bus.clr = '0;
        chk("clr_all_pend", 32'(bus.pending), 0);
        chk("clr_all_cnt", 32'(bus.event_cnt), 0);
        chk("clr_all_irq", 32'(bus.irq), 0);

        // Clear coinciding with an event on channel 2: set wins, count restarts at 1.
        bus.rise_en[2] = 1'b1;
        bus.din[2]     = 1'b1;
        tick(6);
        chk("clr_pri_pulse", 32'(bus.rise_pulse[2]), 1);
        bus.clr[2] = 1'b1;
        tick(1);
        bus.clr[2] = 1'b0;
        chk("clr_pri_pend", 32'(bus.pending[2]), 1);
        chk("clr_pri_cnt", 32'(cnt_of(2)), 1);
        chk("clr_pri_irq", 32'(bus.irq), 1);
        bus.clr[2] = 1'b1;
        tick(1);
        bus.clr[2] = 1'b0;
        chk("clr_only_pend", 32'(bus.pending[2]), 0);
        chk("clr_only_cnt", 32'(cnt_of(2)), 0);
        chk("clr_only_irq", 32'(bus.irq), 0);

        // Saturation of the 2-bit counter on channel 4.
        bus.rise_en[4] = 1'b1;
        bus.fall_en[4] = 1'b1;
        repeat (2) begin
            bus.din[4] = ~bus.din[4];
            tick(8);
        end
        chk("sat_cnt2", 32'(cnt_of(4)), 2);
        repeat (3) begin
            bus.din[4] = ~bus.din[4];
            tick(8);
        end
        chk("sat_cnt5", 32'(cnt_of(4)), 3);
        chk("sat_level", 32'(bus.level[4]), 1);

        // Reset while channel 5 filter count is 2, then a fresh full-latency rise.
        bus.rise_en[5] = 1'b1;
        bus.din[5]     = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_level", 32'(bus.level), 0);
        chk("mid_rst_pulses", 32'(bus.rise_pulse | bus.fall_pulse), 0);
        chk("mid_rst_pend", 32'(bus.pending), 0);
        chk("mid_rst_cnt", 32'(bus.event_cnt), 0);
        chk("mid_rst_irq", 32'(bus.irq), 0);
        tick(5);
        chk("post_rst_level_e4", 32'(bus.level[5]), 0);
        tick(1);
        chk("post_rst_level_e5", 32'(bus.level[5]), 1);
        chk("post_rst_pulse_e5", 32'(bus.rise_pulse[5]), 1);
        tick(1);
        chk("post_rst_pend", 32'(bus.pending[5]), 1);
        chk("post_rst_cnt", 32'(cnt_of(5)), 1);
        chk("post_rst_irq", 32'(bus.irq), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
